// File: rtl/video_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen_if
// Purpose  : Raster timing bundle between the timing generator and its users.
// Revision : 1.0
// ============================================================================
interface video_timing_gen_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  logic          i_en;
  logic [XW-1:0] o_x;
  logic [YW-1:0] o_y;
  logic          o_hsync;
  logic          o_vsync;
  logic          o_blanking;
  logic          o_line_start;
  logic          o_frame_start;

  modport master (
    input  i_en,
    output o_x, o_y, o_hsync, o_vsync, o_blanking, o_line_start, o_frame_start
  );

  modport slave (
    output i_en,
    input  o_x, o_y, o_hsync, o_vsync, o_blanking, o_line_start, o_frame_start
  );
endinterface
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Purpose  : Pixel-clock raster counter with registered sync/blank/strobe flags.
// Revision : 1.0
// ============================================================================
module video_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  video_timing_gen_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);

  localparam logic [XW-1:0] C_X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] C_X_ACTEND = XW'(H_ACTIVE);
  localparam logic [XW-1:0] C_X_HSBEG  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] C_X_HSEND  = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] C_Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] C_Y_ACTEND = YW'(V_ACTIVE);
  localparam logic [YW-1:0] C_Y_VSBEG  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] C_Y_VSEND  = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          C_HS_ON    = H_SYNC_POL[0];
  localparam logic          C_VS_ON    = V_SYNC_POL[0];

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      H_TOTAL < 4 || V_TOTAL < 4) begin : g_param_check
    $error("video_timing_gen: illegal timing parameters");
  end

  logic [XW-1:0] x_q, x_d, x_nxt;
  logic [YW-1:0] y_q, y_d, y_nxt;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          blanking_q, blanking_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  // Flags are decoded from the next position so they land in the same
  // register stage as the coordinates they describe.
  always_comb begin
    x_nxt = (x_q == C_X_LAST) ? '0 : x_q + 1'b1;
    y_nxt = y_q;
    if (x_q == C_X_LAST) begin
      y_nxt = (y_q == C_Y_LAST) ? '0 : y_q + 1'b1;
    end

    x_d           = x_q;
    y_d           = y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    blanking_d    = blanking_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (bus.i_en) begin
      x_d           = x_nxt;
      y_d           = y_nxt;
      blanking_d    = !((x_nxt < C_X_ACTEND) && (y_nxt < C_Y_ACTEND));
      hsync_d       = ((x_nxt >= C_X_HSBEG) && (x_nxt < C_X_HSEND)) ? C_HS_ON : ~C_HS_ON;
      vsync_d       = ((y_nxt >= C_Y_VSBEG) && (y_nxt < C_Y_VSEND)) ? C_VS_ON : ~C_VS_ON;
      line_start_d  = (x_nxt == '0);
      frame_start_d = (x_nxt == '0) && (y_nxt == '0);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~C_HS_ON;
      vsync_q       <= ~C_VS_ON;
      blanking_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blanking_q    <= blanking_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.o_x           = x_q;
  assign bus.o_y           = y_q;
  assign bus.o_hsync       = hsync_q;
  assign bus.o_vsync       = vsync_q;
  assign bus.o_blanking    = blanking_q;
  assign bus.o_line_start  = line_start_q;
  assign bus.o_frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// Bench for video_timing_gen on a shrunken 16x10 raster (8x6 active) so whole
// frames fit in a short run; hsync active-low, vsync active-high.
`timescale 1ns/1ps
module tb_video_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;   // 16
  localparam int VT = VA + VF + VS + VB;   // 10
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic       hs;
    logic       vs;
    logic       bl;
    logic       ls;
    logic       fs;
    logic       cnt;
    int         tag;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  video_timing_gen_if #(.XW(XW), .YW(YW)) bus ();

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_SYNC_POL(0), .V_SYNC_POL(1)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n       = 0;   // advances since last reset
  int   tag     = 0;
  int   cnt_ls = 0, cnt_fs = 0, cnt_act = 0, cnt_hs = 0, cnt_vs = 0;

  // Expected outputs after nn advances; position comes from a flat index
  // into the frame, flags from the geometry above.
  function automatic exp_t model(int nn, bit adv, bit cnt, int t);
    exp_t e;
    int pos, x, y;
    pos   = nn % (HT * VT);
    x     = pos % HT;
    y     = pos / HT;
    e.x   = 4'(x);
    e.y   = 4'(y);
    e.hs  = !(x >= 10 && x <= 12);
    e.vs  = (y == 7 || y == 8);
    e.bl  = !(x <= 7 && y <= 5);
    e.ls  = adv && (x == 0);
    e.fs  = adv && (pos == 0);
    e.cnt = cnt;
    e.tag = t;
    return e;
  endfunction

  task automatic check_now(string name, exp_t e);
    logic [14:0] act, req;
    act = {bus.o_x, bus.o_y, bus.o_hsync, bus.o_vsync, bus.o_blanking,
           bus.o_line_start, bus.o_frame_start};
    req = {e.x, e.y, e.hs, e.vs, e.bl, e.ls, e.fs};
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s #%0d: got {x,y,hs,vs,bl,ls,fs}=%h expected %h", name, e.tag, act, req);
  endtask

  task automatic check_count(string name, int act, int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  // Monitor: one expectation per clock, sampled 1ns after the active edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check_now("scoreboard", e);
      if (e.cnt && (bus.i_en === 1'b1 || e.ls || e.fs || 1'b1)) begin
        if (bus.o_line_start)  cnt_ls++;
        if (bus.o_frame_start) cnt_fs++;
        if (!bus.o_blanking)   cnt_act++;
        if (!bus.o_hsync)      cnt_hs++;
        if (bus.o_vsync)       cnt_vs++;
      end
    end
  end

  // One stimulus cycle; cnt marks advances inside the frame-statistics window.
  task automatic step(bit en, bit cnt);
    @(negedge clk);
    bus.i_en = en;
    if (en) n++;
    tag++;
    q.push_back(model(n, en, cnt && en, tag));
  endtask

  initial begin
    bus.i_en = 1'b0;
    rst_n    = 1'b0;

    // Held in reset: reset values, no strobes.
    repeat (3) begin
      @(negedge clk);
      tag++;
      q.push_back(model(0, 1'b0, 1'b0, tag));
    end

    // Release with enable low: position must not move and no strobe appears.
    @(negedge clk);
    rst_n = 1'b1;
    n     = 0;
    tag++;
    q.push_back(model(0, 1'b0, 1'b0, tag));

    // First line and wrap into line 1, then run to the last pixel of the frame.
    while (n < HT * VT - 1) step(1'b1, 1'b0);

    // Freeze at (15,9) for five cycles, then wrap to (0,0).
    repeat (5) step(1'b0, 1'b0);
    step(1'b1, 1'b0);

    // One complete frame of advances (ending back at (0,0)) with periodic stalls.
    for (int i = 0; n < 2 * HT * VT; i++) begin
      if (i % 7 == 6) step(1'b0, 1'b0);
      else            step(1'b1, 1'b1);
    end

    // Move mid-frame, then assert reset between clock edges.
    repeat (3 * HT + 5) step(1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_now("async_reset", model(0, 1'b0, 1'b0, -1));
    @(negedge clk);
    bus.i_en = 1'b1;
    tag++;
    q.push_back(model(0, 1'b0, 1'b0, tag));
    @(negedge clk);
    rst_n = 1'b1;
    n     = 1;
    tag++;
    q.push_back(model(1, 1'b1, 1'b0, tag));
    repeat (4) step(1'b1, 1'b0);

    @(negedge clk);
    @(negedge clk);
    check_count("queue_drained", q.size(), 0);
    check_count("frame_start_pulses", cnt_fs, 1);
    check_count("line_start_pulses", cnt_ls, VT);
    check_count("active_cycles", cnt_act, HA * VA);
    check_count("hsync_cycles", cnt_hs, HS * VT);
    check_count("vsync_cycles", cnt_vs, VS * HT);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
